// File: rtl/uart_rx_fifo_if.sv
// CPU-side register interface of the buffered UART receiver: FIFO read port,
// occupancy and sticky error flags.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int NW = $clog2(DEPTH + 1);

  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [NW-1:0] count;
  logic          clr_err;
  logic          overrun;
  logic          frame_err;
  logic          parity_err;

  modport master (
    output rd_en, clr_err,
    input  rd_data, rd_valid, count, overrun, frame_err, parity_err
  );

  modport slave (
    input  rd_en, clr_err,
    output rd_data, rd_valid, count, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: 2-flop synchroniser, 8N1 deserialiser and small FWFT FIFO
// with RTS flow control. Define UART_RX_FIFO_PARITY_EN for 8E1 frames with parity check.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BIT_RATE   = 28_800,
  parameter int DEPTH      = 4,
  parameter int RTS_THRESH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           uart_rxd,
  output logic           uart_rts,
  uart_rx_fifo_if.slave  bus
);
  localparam int CYCLES = CLK_HZ / BIT_RATE;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int NW     = $clog2(DEPTH + 1);

`ifdef UART_RX_FIFO_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------- receiver ----------------
  logic [1:0]    rxd_sync;
  logic          rxd_s;
  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          push_req, push_n;
  logic [7:0]    push_data, push_dat_n;
  logic          frame_ev, parity_ev, par_ok;

`ifdef UART_RX_FIFO_PARITY_EN
  logic par_bad, par_bad_n;
  assign par_ok = ~par_bad;
`else
  assign par_ok = 1'b1;
`endif

  assign rxd_s = rxd_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_sync  <= 2'b11;
      state     <= IDLE;
      cyc       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
`ifdef UART_RX_FIFO_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      rxd_sync  <= {rxd_sync[0], uart_rxd};
      state     <= state_n;
      cyc       <= cyc_n;
      bit_idx   <= bit_n;
      shreg     <= sh_n;
      push_req  <= push_n;
      push_data <= push_dat_n;
`ifdef UART_RX_FIFO_PARITY_EN
      par_bad   <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cyc_n      = cyc;
    bit_n      = bit_idx;
    sh_n       = shreg;
    push_n     = 1'b0;
    push_dat_n = push_data;
    frame_ev   = 1'b0;
    parity_ev  = 1'b0;
`ifdef UART_RX_FIFO_PARITY_EN
    par_bad_n  = par_bad;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cyc_n   = '0;
          bit_n   = '0;
`ifdef UART_RX_FIFO_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end
      end
      START: begin
        // a start bit that is high again at mid-bit was only a glitch
        if (cyc == CW'(CYCLES / 2)) begin
          cyc_n   = '0;
          state_n = rxd_s ? IDLE : DATA;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      DATA: begin
        if (cyc == CW'(CYCLES - 1)) begin
          cyc_n = '0;
          sh_n  = {rxd_s, shreg[7:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_FIFO_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
`ifdef UART_RX_FIFO_PARITY_EN
      PARITY: begin
        if (cyc == CW'(CYCLES - 1)) begin
          cyc_n   = '0;
          state_n = STOP;
          if (^{shreg, rxd_s}) begin
            par_bad_n = 1'b1;
            parity_ev = 1'b1;
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
`endif
      STOP: begin
        // leave at mid stop bit so an immediately following start edge is caught
        if (cyc == CW'(CYCLES - 1)) begin
          cyc_n   = '0;
          state_n = IDLE;
          if (!rxd_s) begin
            frame_ev = 1'b1;
          end else if (par_ok) begin
            push_n     = 1'b1;
            push_dat_n = shreg;
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- FIFO ----------------
  logic [DEPTH-1:0][7:0] mem;
  logic [PW-1:0]         wptr, rptr;
  logic [NW-1:0]         cnt, cnt_n;
  logic                  full, do_pop, do_push, ovr_ev;
  logic                  ovr_q, fe_q, pe_q;

  assign full    = (cnt == NW'(DEPTH));
  assign do_pop  = bus.rd_en && (cnt != '0);
  assign do_push = push_req && (!full || do_pop);
  assign ovr_ev  = push_req && full && !do_pop;
  assign cnt_n   = cnt + NW'(do_push) - NW'(do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      uart_rts <= 1'b0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      cnt      <= cnt_n;
      uart_rts <= (cnt_n >= NW'(RTS_THRESH));
      // an error event in the clearing cycle keeps its flag set
      ovr_q    <= (ovr_q & ~bus.clr_err) | ovr_ev;
      fe_q     <= (fe_q  & ~bus.clr_err) | frame_ev;
      pe_q     <= (pe_q  & ~bus.clr_err) | parity_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign bus.rd_valid  = (cnt != '0);
  assign bus.rd_data   = bus.rd_valid ? mem[rptr] : 8'h00;
  assign bus.count     = cnt;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = fe_q;
`ifdef UART_RX_FIFO_PARITY_EN
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames driven bit by bit, checked
// against a queue-based model of received bytes and sticky flags.
module tb_uart_rx_fifo;
  localparam int CLK_HZ   = 12_000_000;
  localparam int BIT_RATE = 28_800;
  localparam int CYCLES   = CLK_HZ / BIT_RATE;
  localparam int DEPTH    = 4;
  localparam int THRESH   = 3;
`ifdef UART_RX_FIFO_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // negedges from start-bit launch to the cycle whose closing edge performs the push:
  // 2 sync + 1 start detect + half bit + data/parity/stop bits + 1 push delay
  localparam int PUSH_NEG = 4 + CYCLES / 2 + NBITS * CYCLES;

  logic clk = 1'b0;
  logic rst_n, uart_rxd, uart_rts;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .DEPTH(DEPTH), .RTS_THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .uart_rts(uart_rts), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic m_ovr, m_fe, m_pe;

  // drive one frame; starts and ends on a negedge
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    uart_rxd = 1'b0;
    repeat (CYCLES) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (CYCLES) @(negedge clk);
    end
`ifdef UART_RX_FIFO_PARITY_EN
    uart_rxd = (^d) ^ par_flip;
    repeat (CYCLES) @(negedge clk);
`endif
    uart_rxd = stop_bit;
    repeat (CYCLES) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    logic pbad;
`ifdef UART_RX_FIFO_PARITY_EN
    pbad = par_flip;
`else
    pbad = 1'b0;
`endif
    if (pbad) m_pe = 1'b1;
    if (!stop_bit) m_fe = 1'b1;
    else if (!pbad) begin
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic rx(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_frame(d, stop_bit, par_flip);
    model_frame(d, stop_bit, par_flip);
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_rxd = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q.delete(); m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if ({bus.rd_valid, bus.rd_data} !== 9'h000) begin bad++; $display("FAIL reset_rd got=%b/%h exp=0/00", bus.rd_valid, bus.rd_data); end
    total++; if ({uart_rts, bus.overrun, bus.frame_err, bus.parity_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {uart_rts, bus.overrun, bus.frame_err, bus.parity_err}); end
  endtask

  task automatic test_single();
    rx(8'hA5, 1'b1, 1'b0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%b/%h exp=1/a5", bus.rd_valid, bus.rd_data); end
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    pop_one();
    total++; if (bus.rd_valid !== 1'b0 || bus.count !== 3'd0 || bus.rd_data !== 8'h00) begin bad++; $display("FAIL single_pop got=%b/%0d/%h exp=0/0/00", bus.rd_valid, bus.count, bus.rd_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      rx(8'(i), 1'b1, 1'b0);
      if (i == 2) begin
        total++; if (uart_rts !== 1'b0) begin bad++; $display("FAIL b2b_rts_2 got=%b exp=0", uart_rts); end
      end
      if (i == 3) begin
        total++; if (uart_rts !== 1'b1) begin bad++; $display("FAIL b2b_rts_3 got=%b exp=1", uart_rts); end
      end
    end
    total++; if (bus.overrun !== 1'b1 || bus.count !== 3'd4) begin bad++; $display("FAIL b2b_overrun got=%b/%0d exp=1/4", bus.overrun, bus.count); end
    for (int i = 1; i <= 4; i++) begin
      total++; if (bus.rd_data !== 8'(i)) begin bad++; $display("FAIL b2b_read%0d got=%h exp=%h", i, bus.rd_data, 8'(i)); end
      pop_one();
    end
    total++; if (bus.rd_valid !== 1'b0 || uart_rts !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b/%b exp=0/0", bus.rd_valid, uart_rts); end
    clear_errs();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_clr got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_glitch();
    uart_rxd = 1'b0;
    repeat (100) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CYCLES) @(negedge clk);
    total++; if (bus.count !== 3'd0 || {bus.overrun, bus.frame_err, bus.parity_err} !== 3'b000) begin bad++; $display("FAIL glitch got=%0d/%b exp=0/000", bus.count, {bus.overrun, bus.frame_err, bus.parity_err}); end
  endtask

  task automatic test_frame_err();
    rx(8'h3C, 1'b0, 1'b0);
    repeat (CYCLES) @(negedge clk);
    total++; if (bus.frame_err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL ferr_flag got=%b/%0d exp=1/0", bus.frame_err, bus.count); end
    rx(8'h7E, 1'b1, 1'b0);
    total++; if (bus.rd_data !== 8'h7E || bus.count !== 3'd1) begin bad++; $display("FAIL ferr_next got=%h/%0d exp=7e/1", bus.rd_data, bus.count); end
    pop_one();
    clear_errs();
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b exp=0", bus.frame_err); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] d5;
    for (int i = 0; i < DEPTH; i++) rx(8'($urandom), 1'b1, 1'b0);
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_fill got=%0d exp=4", bus.count); end
    d5 = 8'($urandom);
    fork
      send_frame(d5, 1'b1, 1'b0);
      begin
        repeat (PUSH_NEG) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
      end
    join
    void'(q.pop_front());
    q.push_back(d5);
    total++; if (bus.overrun !== 1'b0 || bus.count !== 3'd4 || uart_rts !== 1'b1) begin bad++; $display("FAIL full_pushpop got=%b/%0d/%b exp=0/4/1", bus.overrun, bus.count, uart_rts); end
    while (q.size() != 0) begin
      total++; if (bus.rd_data !== q[0]) begin bad++; $display("FAIL full_order got=%h exp=%h", bus.rd_data, q[0]); end
      pop_one();
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic sb;
    int n;
    for (int f = 0; f < 3; f++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rx(d, sb, 1'b0);
      repeat (CYCLES) @(negedge clk);
      total++; if (bus.count !== 3'(q.size()) || bus.rd_data !== (q.size() != 0 ? q[0] : 8'h00)) begin bad++; $display("FAIL rnd_fifo f=%0d got=%0d/%h exp=%0d/%h", f, bus.count, bus.rd_data, q.size(), (q.size() != 0 ? q[0] : 8'h00)); end
      total++; if ({uart_rts, bus.overrun, bus.frame_err} !== {(q.size() >= THRESH), m_ovr, m_fe}) begin bad++; $display("FAIL rnd_flags f=%0d got=%b exp=%b", f, {uart_rts, bus.overrun, bus.frame_err}, {(q.size() >= THRESH), m_ovr, m_fe}); end
      n = $urandom_range(0, 2);
      for (int r = 0; r < n; r++) pop_one();
    end
    clear_errs();
  endtask

`ifdef UART_RX_FIFO_PARITY_EN
  task automatic test_parity();
    while (q.size() != 0) pop_one();
    rx(8'h07, 1'b1, 1'b1);
    total++; if (bus.parity_err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL par_bad got=%b/%0d exp=1/0", bus.parity_err, bus.count); end
    rx(8'h07, 1'b1, 1'b0);
    total++; if (bus.rd_data !== 8'h07 || bus.count !== 3'd1) begin bad++; $display("FAIL par_ok got=%h/%0d exp=07/1", bus.rd_data, bus.count); end
    clear_errs();
  endtask
`endif

  task automatic test_reset_mid();
    uart_rxd = 1'b0;
    repeat (CYCLES) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = i[0];
      repeat (CYCLES) @(negedge clk);
    end
    rst_n = 1'b0; uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete(); m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
    @(negedge clk);
    total++; if (bus.count !== 3'd0 || uart_rts !== 1'b0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_now got=%0d/%b/%b exp=0/0/0", bus.count, uart_rts, bus.rd_valid); end
    repeat (NBITS * CYCLES) @(negedge clk);
    total++; if (bus.count !== 3'd0 || {bus.overrun, bus.frame_err, bus.parity_err} !== 3'b000) begin bad++; $display("FAIL rstmid_later got=%0d/%b exp=0/000", bus.count, {bus.overrun, bus.frame_err, bus.parity_err}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_full_pushpop();
    test_random();
`ifdef UART_RX_FIFO_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
